// File: rtl/button_irq_ctrl_if.sv
// Button interrupt controller bus.
// The cpu side (master) drives the raw buttons, the enable mask and the ack/clear
// pulses. The controller (slave) returns the interrupt vector, the winning id and
// the sticky overflow flags.
//  buttons   raw async button levels   (master -> slave)
//  enable    per-source mask           (master -> slave)
//  ack       1-cycle ack pulse          (master -> slave)
//  ack_id    source index being acked  (master -> slave)
//  clear_all 1-cycle global clear       (master -> slave)
//  intr      pending & enable, zero-ext (slave -> master)
//  irq_any   |intr                      (slave -> master)
//  irq_id    lowest set index of intr   (slave -> master)
//  overflow  sticky press-while-pending (slave -> master)
interface button_irq_ctrl_if #(
  parameter int N_SRC  = 4,
  parameter int INTR_W = 8,
  parameter int ID_W   = 3
);
  logic [N_SRC-1:0]  buttons;
  logic [N_SRC-1:0]  enable;
  logic              ack;
  logic [ID_W-1:0]   ack_id;
  logic              clear_all;
  logic [INTR_W-1:0] intr;
  logic              irq_any;
  logic [ID_W-1:0]   irq_id;
  logic [N_SRC-1:0]  overflow;

  modport master (
    output buttons, enable, ack, ack_id, clear_all,
    input  intr, irq_any, irq_id, overflow
  );

  modport slave (
    input  buttons, enable, ack, ack_id, clear_all,
    output intr, irq_any, irq_id, overflow
  );
endinterface

// File: rtl/button_irq_ctrl.sv
// button_lane: one button source.
// Runs a 2-flop synchroniser, converts polarity to active-high "pressed" and
// debounces. It emits a 1-cycle press pulse on an accepted 0->1 edge.
//  clk, reset  clock, synchronous active-high reset
//  raw         raw asynchronous button level
//  press       registered 1-cycle pulse on accepted press
module button_lane #(
  parameter int DEB_CYCLES = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int        CW   = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  // Raw level of a released button, so reset leaves the synchroniser idle.
  localparam logic      REL  = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          pressed;

  assign pressed = ACTIVE_LOW ? ~sync[1] : sync[1];

  // The counter commits at LAST and restarts from 0, so it never passes LAST.
  // It can neither wrap nor overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= {2{REL}};
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (pressed == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= pressed;
        cnt    <= '0;
        press  <= pressed;   // only the 0->1 edge is an event
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// button_irq_ctrl: N_SRC debounced buttons -> sticky pending bits -> masked intr.
//  clk       system clock
//  reset     synchronous active-high reset, dominates everything
//  bus       button_irq_ctrl_if slave: buttons/enable/ack/ack_id/clear_all in,
//            intr/irq_any/irq_id/overflow out (all outputs registered)
module button_irq_ctrl #(
  parameter int N_SRC      = 4,
  parameter int INTR_W     = 8,
  parameter int DEB_CYCLES = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int ID_W       = 3
) (
  input  logic clk,
  input  logic reset,
  button_irq_ctrl_if.slave bus
);
  logic [N_SRC-1:0]  raw;
  logic [N_SRC-1:0]  press;
  logic [N_SRC-1:0]  ack_hit;
  logic [N_SRC-1:0]  pend, pend_nxt;
  logic [N_SRC-1:0]  ovf, ovf_nxt;
  logic [INTR_W-1:0] intr_q, intr_nxt;
  logic              any_q, any_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;

  assign raw = bus.buttons;

  button_lane #(
    .DEB_CYCLES (DEB_CYCLES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_lane [N_SRC-1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .press (press)
  );

  // Per-bit priority: clear_all > press > ack. A press that lands together with
  // an ack wins, so that press is not lost, and overflow keeps its value.
  // An ack_id beyond N_SRC matches no bit.
  always_comb begin
    ack_hit  = '0;
    pend_nxt = pend;
    ovf_nxt  = ovf;
    for (int i = 0; i < N_SRC; i++) begin
      ack_hit[i] = bus.ack && (bus.ack_id == ID_W'(i));
      if (bus.clear_all) begin
        pend_nxt[i] = 1'b0;
        ovf_nxt[i]  = 1'b0;
      end else if (press[i]) begin
        pend_nxt[i] = 1'b1;
        if (pend[i] && !ack_hit[i]) ovf_nxt[i] = 1'b1;
      end else if (ack_hit[i]) begin
        pend_nxt[i] = 1'b0;
        ovf_nxt[i]  = 1'b0;
      end
    end
  end

  // The outputs are derived from next-state pending. This way intr moves on the
  // same edge as pending. The downward scan leaves the lowest set index in id_nxt.
  always_comb begin
    intr_nxt              = '0;
    intr_nxt[N_SRC-1:0]   = pend_nxt & bus.enable;
    any_nxt               = |intr_nxt;
    id_nxt                = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (intr_nxt[i]) id_nxt = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend   <= '0;
      ovf    <= '0;
      intr_q <= '0;
      any_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      pend   <= pend_nxt;
      ovf    <= ovf_nxt;
      intr_q <= intr_nxt;
      any_q  <= any_nxt;
      id_q   <= id_nxt;
    end
  end

  assign bus.intr     = intr_q;
  assign bus.irq_any  = any_q;
  assign bus.irq_id   = id_q;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_button_irq_ctrl.sv
module tb_button_irq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  button_irq_ctrl_if #(.N_SRC(4), .INTR_W(8), .ID_W(3)) bif ();

  button_irq_ctrl #(
    .N_SRC(4), .INTR_W(8), .DEB_CYCLES(4), .ACTIVE_LOW(1'b1), .ID_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // Each record holds its inputs for cyc edges. ack and clear_all are asserted
  // only on the first edge. The outputs are checked 1 ns after the last edge.
  typedef struct {
    int         cyc;
    logic [3:0] btn;
    logic [3:0] en;
    logic       ack;
    logic [2:0] id;
    logic       clr;
    logic [7:0] e_intr;
    logic [2:0] e_id;
    logic [3:0] e_ovf;
  } vec_t;

  vec_t vt[$];

  task automatic v(int cyc, logic [3:0] btn, logic [3:0] en, logic ack, logic [2:0] id,
                   logic clr, logic [7:0] e_intr, logic [2:0] e_id, logic [3:0] e_ovf);
    vt.push_back('{cyc, btn, en, ack, id, clr, e_intr, e_id, e_ovf});
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [7:0] e_intr, logic [2:0] e_id, logic [3:0] e_ovf);
    chk({tag, ".intr"},     32'(bif.intr),     32'(e_intr));
    chk({tag, ".irq_any"},  32'(bif.irq_any),  32'(e_intr != 8'h00));
    chk({tag, ".irq_id"},   32'(bif.irq_id),   32'(e_id));
    chk({tag, ".overflow"}, 32'(bif.overflow), 32'(e_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bif.buttons   = 4'b0000;
    bif.enable    = 4'hF;
    bif.ack       = 1'b0;
    bif.ack_id    = '0;
    bif.clear_all = 1'b0;

    // reset held 3 cycles: every output reads 0
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all($sformatf("reset%0d", c), 8'h00, 3'd0, 4'h0);
    end
    reset       = 1'b0;
    bif.buttons = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_all($sformatf("post_reset%0d", c), 8'h00, 3'd0, 4'h0);
    end

    //  cyc btn      en     ack  id    clr   intr   id    ovf
    // single press: latency boundary, release is silent, ack clears
    v(6, 4'b1110, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(1, 4'b1110, 4'hF, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 4'h0);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    // glitch of 3 cycles ignored; 4 cycles accepted
    v(3, 4'b1101, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(4, 4'b1101, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(2, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h02, 3'd1, 4'h0);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h02, 3'd1, 4'h0);
    // ack out of range, ack of a clear bit: no effect
    v(1, 4'b1111, 4'hF, 1'b1, 3'd5, 1'b0, 8'h02, 3'd1, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b1, 3'd0, 1'b0, 8'h02, 3'd1, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b1, 3'd1, 1'b0, 8'h00, 3'd0, 4'h0);
    // bits 1 and 3 together
    v(6, 4'b0101, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(1, 4'b0101, 4'hF, 1'b0, 3'd0, 1'b0, 8'h0A, 3'd1, 4'h0);
    v(1, 4'b0101, 4'hF, 1'b1, 3'd1, 1'b0, 8'h08, 3'd3, 4'h0);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h08, 3'd3, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b1, 8'h00, 3'd0, 4'h0);
    // overflow on bit 2; press coinciding with ack keeps pending and overflow
    v(7, 4'b1011, 4'hF, 1'b0, 3'd0, 1'b0, 8'h04, 3'd2, 4'h0);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h04, 3'd2, 4'h0);
    v(7, 4'b1011, 4'hF, 1'b0, 3'd0, 1'b0, 8'h04, 3'd2, 4'h4);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h04, 3'd2, 4'h4);
    v(6, 4'b1011, 4'hF, 1'b0, 3'd0, 1'b0, 8'h04, 3'd2, 4'h4);
    v(1, 4'b1011, 4'hF, 1'b1, 3'd2, 1'b0, 8'h04, 3'd2, 4'h4);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h04, 3'd2, 4'h4);
    v(1, 4'b1111, 4'hF, 1'b1, 3'd2, 1'b0, 8'h00, 3'd0, 4'h0);
    // masked press stays pending and shows once enabled
    v(6, 4'b1110, 4'h0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(1, 4'b1110, 4'h0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(8, 4'b1111, 4'h0, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(1, 4'b1111, 4'h1, 1'b0, 3'd0, 1'b0, 8'h01, 3'd0, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    // all four at once latch in the same cycle
    v(6, 4'b0000, 4'hF, 1'b0, 3'd0, 1'b0, 8'h00, 3'd0, 4'h0);
    v(1, 4'b0000, 4'hF, 1'b0, 3'd0, 1'b0, 8'h0F, 3'd0, 4'h0);
    v(8, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b0, 8'h0F, 3'd0, 4'h0);
    v(1, 4'b1111, 4'hF, 1'b0, 3'd0, 1'b1, 8'h00, 3'd0, 4'h0);

    foreach (vt[i]) begin
      for (int c = 0; c < vt[i].cyc; c++) begin
        bif.buttons   = vt[i].btn;
        bif.enable    = vt[i].en;
        bif.ack_id    = vt[i].id;
        bif.ack       = vt[i].ack && (c == 0);
        bif.clear_all = vt[i].clr && (c == 0);
        tick();
      end
      chk_all($sformatf("v%0d", i), vt[i].e_intr, vt[i].e_id, vt[i].e_ovf);
    end
    bif.ack       = 1'b0;
    bif.clear_all = 1'b0;

    // reset dominates: pending bit 3 plus bit 0 mid-debounce, then reset
    bif.buttons = 4'b0111;
    repeat (7) tick();
    chk_all("pre_reset", 8'h08, 3'd3, 4'h0);
    bif.buttons = 4'b1110;
    repeat (3) tick();
    reset       = 1'b1;
    bif.buttons = 4'b1111;
    tick();
    chk_all("mid_reset", 8'h00, 3'd0, 4'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_all($sformatf("after_mid_reset%0d", c), 8'h00, 3'd0, 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
